taxi_step: RTL and testbench
============================

// Module: taxi_step
// PURPOSE
//  Sequential Taxi-v3 environment core: holds the current episode state, applies one
//  agent action per handshake, returns next state, reward and done. Its 9-bit
//  encoded_state output feeds the state decoder directly downstream.
//  Encoding: state = ((row*5+col)*5+pass)*4+dest, range 0..499.
//  Locations: 0=R(0,0), 1=G(0,4), 2=Y(4,0), 3=B(4,3); pass 4 = in taxi.
// PARAMETERS
//  LFSR_SEED  16'hACE1  initial LFSR value for episode start draws; 0 is forced to 1
// PORTS
//  clk            in   1   clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  env_reset      in   1   request new random episode (level, sampled each cycle)
//  load_en        in   1   debug: load load_state as the current state
//  load_state     in   9   debug state value; values >= 500 are ignored
//  act_valid      in   1   action offered
//  act_ready      out  1   core accepts an action this cycle
//  action         in   3   0=S 1=N 2=E 3=W 4=pickup 5=dropoff
//  encoded_state  out  9   current encoded state, registered
//  step_valid     out  1   one-cycle pulse: reward/done/encoded_state hold a step result
//  reward         out  8   signed step reward
//  done           out  1   episode finished; held until env_reset or load_en
// BEHAVIOUR
//  - Reset values: encoded_state=0, step_valid=0, reward=0, done=0, act_ready=0,
//    lfsr=LFSR_SEED, FSM=SEED.
//  - FSM states: SEED, READY, DONE. act_ready=1 only in READY.
//  - Command priority each cycle: env_reset > load_en > action accept.
//  - Accept = act_valid & act_ready & ~env_reset & ~load_en.
//  - env_reset in any state -> SEED; clear done and step_valid. No step is produced.
//  - load_en with load_state < 500 -> encoded_state <= load_state, done <= 0,
//    FSM -> READY, no step_valid pulse. load_state >= 500 is ignored.
//  - SEED state:
//    - 16-bit Fibonacci LFSR advances every cycle, polynomial x^16+x^15+x^13+x^4+1.
//    - Candidate fields: row=lfsr[2:0], col=lfsr[5:3], pass=lfsr[7:6], dest=lfsr[9:8].
//    - Candidate accepted only if row<5, col<5 and pass!=dest; otherwise retry next cycle.
//    - On accept: encoded_state is loaded and FSM -> READY.
//  - Step latency: action accepted at edge T -> encoded_state/reward/done updated and
//    step_valid=1 for exactly one cycle after T. FSM -> DONE if done, else READY.
//    Back-to-back accepts are allowed in consecutive cycles.
//  - Moves, reward -1:
//    - S: row+1 if row<4.
//    - N: row-1 if row>0.
//    - E: col+1 unless col=4 or (row,col) in {(0,1),(1,1),(3,0),(4,0),(3,2),(4,2)}.
//    - W: col-1 unless col=0 or (row,col) in {(0,2),(1,2),(3,1),(4,1),(3,3),(4,3)}.
//    - A blocked move leaves the state unchanged; reward is still -1.
//  - Pickup:
//    - pass<4 and taxi at loc[pass]: pass=4, reward -1.
//    - Otherwise: state unchanged, reward -10.
//  - Dropoff:
//    - pass=4 and taxi at loc[dest]: pass=dest, reward +20, done=1.
//    - pass=4 and taxi at another location k: pass=k, reward -1.
//    - Otherwise: state unchanged, reward -10.
//  - Actions 6/7: state unchanged, reward -10, done unchanged.
//  - DONE state: act_ready=0; leaves only via env_reset or load_en.
//  - Arithmetic: encoded_state built with row*100+col*20+pass*4+dest, 9-bit result.
//    Decode of the current state uses /4, /5 on registered state only; no comb loop
//    through action.
//  - rst_n asserted mid-step discards the pending result; outputs return to reset values.
// TESTING
//  1. Release rst_n, idle: within 64 cycles act_ready=1; encoded_state<500; decoded
//     pass!=dest; all outputs 0 before release.
//  2. load 246 (r2,c2,p1,d2), action N -> next cycle encoded_state=146, reward=-1,
//     step_valid=1, done=0.
//  3. Wall/edge: load 21 (r0,c1,p0,d1), action E -> state 21, reward -1. load 446 (r4),
//     action S -> state 446, reward -1.
//  4. load 1 (r0,c0,p0,d1), pickup -> 17, reward -1; pickup again -> 17, reward -10;
//     action 7 -> 17, reward -10.
//  5. load 97 (r0,c4,p4,d1), dropoff -> 85, reward +20, done=1, act_ready=0; further
//     act_valid ignored.
//  6. In READY, assert env_reset and act_valid same cycle -> no step_valid, FSM SEED;
//     rst_n pulse during step -> all outputs reset.

Source files
------------

// File: rtl/taxi_step.sv
// Taxi-v3 environment core: holds the encoded episode state, applies one
// action per accepted handshake and reports next state, reward and done.
//
// Handshake: an action transfers on a rising edge where act_valid and
// act_ready are both high and neither env_reset nor load_en is asserted.
// act_ready is a pure function of the registered FSM state (high only in
// READY), so it never depends combinationally on act_valid or action.
module taxi_step #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       env_reset,
  input  logic       load_en,
  input  logic [8:0] load_state,
  input  logic       act_valid,
  output logic       act_ready,
  input  logic [2:0] action,
  output logic [8:0] encoded_state,
  output logic       step_valid,
  output logic [7:0] reward,
  output logic       done
);

  typedef enum logic [1:0] {ST_SEED, ST_READY, ST_DONE} state_e;

  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  localparam logic [7:0] RW_STEP = 8'hFF; // -1
  localparam logic [7:0] RW_BAD  = 8'hF6; // -10
  localparam logic [7:0] RW_WIN  = 8'h14; // +20

  state_e      state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [8:0]  enc_q, enc_d;
  logic        step_valid_q, step_valid_d;
  logic [7:0]  reward_q, reward_d;
  logic        done_q, done_d;

  // Landmark lookup: {hit, index} for the taxi position.
  function automatic logic [2:0] loc_at(input logic [8:0] r, input logic [8:0] c);
    logic [2:0] res;
    res = 3'b000;
    if (r == 9'd0 && c == 9'd0) res = 3'b100;
    if (r == 9'd0 && c == 9'd4) res = 3'b101;
    if (r == 9'd4 && c == 9'd0) res = 3'b110;
    if (r == 9'd4 && c == 9'd3) res = 3'b111;
    return res;
  endfunction

  // Cells whose east side has a wall.
  function automatic logic east_wall(input logic [8:0] r, input logic [8:0] c);
    return ((r <= 9'd1) && (c == 9'd1)) ||
           ((r >= 9'd3) && ((c == 9'd0) || (c == 9'd2)));
  endfunction

  // Cells whose west side has a wall.
  function automatic logic west_wall(input logic [8:0] r, input logic [8:0] c);
    return ((r <= 9'd1) && (c == 9'd2)) ||
           ((r >= 9'd3) && ((c == 9'd1) || (c == 9'd3)));
  endfunction

  // Decode of the registered state and episode-start candidate.
  logic [8:0] q4, q20, cur_row, cur_col, cur_pass, cur_dest;
  logic [8:0] cand_row, cand_col, cand_pass, cand_dest, cand_enc;
  logic       cand_ok, lfsr_fb;
  always_comb begin
    q4        = enc_q >> 2;
    cur_dest  = {7'd0, enc_q[1:0]};
    cur_pass  = q4 % 9'd5;
    q20       = q4 / 9'd5;
    cur_col   = q20 % 9'd5;
    cur_row   = q20 / 9'd5;
    cand_row  = {6'd0, lfsr_q[2:0]};
    cand_col  = {6'd0, lfsr_q[5:3]};
    cand_pass = {7'd0, lfsr_q[7:6]};
    cand_dest = {7'd0, lfsr_q[9:8]};
    cand_ok   = (cand_row < 9'd5) && (cand_col < 9'd5) && (cand_pass != cand_dest);
    cand_enc  = cand_row * 9'd100 + cand_col * 9'd20 + cand_pass * 9'd4 + cand_dest;
    lfsr_fb   = lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3];
  end

  // Step result for the offered action, computed from registered state only.
  logic [8:0] nrow, ncol, npass, step_enc;
  logic [7:0] step_reward;
  logic       step_done;
  logic [2:0] here;
  always_comb begin
    nrow        = cur_row;
    ncol        = cur_col;
    npass       = cur_pass;
    step_reward = RW_STEP;
    step_done   = 1'b0;
    here        = loc_at(cur_row, cur_col);
    case (action)
      3'd0: if (cur_row < 9'd4) nrow = cur_row + 9'd1;
      3'd1: if (cur_row > 9'd0) nrow = cur_row - 9'd1;
      3'd2: if (cur_col < 9'd4 && !east_wall(cur_row, cur_col)) ncol = cur_col + 9'd1;
      3'd3: if (cur_col > 9'd0 && !west_wall(cur_row, cur_col)) ncol = cur_col - 9'd1;
      3'd4: begin
        if (cur_pass < 9'd4 && here[2] && (here[1:0] == cur_pass[1:0])) npass = 9'd4;
        else step_reward = RW_BAD;
      end
      3'd5: begin
        if (cur_pass == 9'd4 && here[2]) begin
          npass = {7'd0, here[1:0]};
          if (here[1:0] == cur_dest[1:0]) begin
            step_reward = RW_WIN;
            step_done   = 1'b1;
          end
        end else begin
          step_reward = RW_BAD;
        end
      end
      default: step_reward = RW_BAD;
    endcase
    step_enc = nrow * 9'd100 + ncol * 9'd20 + npass * 9'd4 + cur_dest;
  end

  // Next-state logic: env_reset beats load_en beats an action accept.
  always_comb begin
    state_d      = state_q;
    lfsr_d       = {lfsr_q[14:0], lfsr_fb};
    enc_d        = enc_q;
    step_valid_d = 1'b0;
    reward_d     = reward_q;
    done_d       = done_q;
    if (env_reset) begin
      state_d = ST_SEED;
      done_d  = 1'b0;
    end else if (load_en) begin
      if (load_state < 9'd500) begin
        enc_d   = load_state;
        done_d  = 1'b0;
        state_d = ST_READY;
      end
    end else begin
      case (state_q)
        ST_SEED: begin
          if (cand_ok) begin
            enc_d   = cand_enc;
            state_d = ST_READY;
          end
        end
        ST_READY: begin
          if (act_valid) begin
            enc_d        = step_enc;
            reward_d     = step_reward;
            done_d       = step_done;
            step_valid_d = 1'b1;
            state_d      = step_done ? ST_DONE : ST_READY;
          end
        end
        default: ;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_SEED;
      lfsr_q       <= SEED_EFF;
      enc_q        <= 9'd0;
      step_valid_q <= 1'b0;
      reward_q     <= 8'd0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      enc_q        <= enc_d;
      step_valid_q <= step_valid_d;
      reward_q     <= reward_d;
      done_q       <= done_d;
    end
  end

  assign act_ready     = (state_q == ST_READY);
  assign encoded_state = enc_q;
  assign step_valid    = step_valid_q;
  assign reward        = reward_q;
  assign done          = done_q;

endmodule

// File: tb/tb_taxi_step.sv
// Bench for taxi_step: directed scenarios plus randomised single steps.
// Step results are scored against a queue of expected {state, reward, done}.
module tb_taxi_step;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       env_reset = 1'b0;
  logic       load_en = 1'b0;
  logic [8:0] load_state = 9'd0;
  logic       act_valid = 1'b0;
  logic       act_ready;
  logic [2:0] action = 3'd0;
  logic [8:0] encoded_state;
  logic       step_valid;
  logic [7:0] reward;
  logic       done;

  int n_vec = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];

  taxi_step dut (
    .clk(clk), .rst_n(rst_n), .env_reset(env_reset), .load_en(load_en),
    .load_state(load_state), .act_valid(act_valid), .act_ready(act_ready),
    .action(action), .encoded_state(encoded_state), .step_valid(step_valid),
    .reward(reward), .done(done)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every step_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n && step_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_step: got state=%0d reward=%0d done=%0d, expected no step",
                 encoded_state, $signed(reward), done);
      end else begin
        e = exp_q.pop_front();
        if ({encoded_state, reward, done} !== e) begin
          n_err++;
          $display("FAIL step_result: got state=%0d reward=%0d done=%0d, expected state=%0d reward=%0d done=%0d",
                   encoded_state, $signed(reward), done, e[17:9], $signed(e[8:1]), e[0]);
        end
      end
    end
  end

  // Independent reference model of one environment step.
  function automatic logic [17:0] model(input int s, input int a);
    int r, c, p, d, rw, k, ns;
    logic dn;
    int lr[4] = '{0, 0, 4, 4};
    int lc[4] = '{0, 4, 0, 3};
    r = s / 100; c = (s / 20) % 5; p = (s / 4) % 5; d = s % 4;
    rw = -1; dn = 1'b0; k = -1;
    for (int i = 0; i < 4; i++) if (r == lr[i] && c == lc[i]) k = i;
    case (a)
      0: if (r < 4) r = r + 1;
      1: if (r > 0) r = r - 1;
      2: if (c < 4 && !((r <= 1 && c == 1) || (r >= 3 && (c == 0 || c == 2)))) c = c + 1;
      3: if (c > 0 && !((r <= 1 && c - 1 == 1) || (r >= 3 && (c - 1 == 0 || c - 1 == 2)))) c = c - 1;
      4: if (p < 4 && k == p) p = 4; else rw = -10;
      5: begin
        if (p == 4 && k >= 0) begin
          p = k;
          if (k == d) begin rw = 20; dn = 1'b1; end
        end else rw = -10;
      end
      default: rw = -10;
    endcase
    ns = r * 100 + c * 20 + p * 4 + d;
    return {ns[8:0], rw[7:0], dn};
  endfunction

  // Driver tasks.
  task automatic load(input logic [8:0] v);
    @(negedge clk);
    load_en = 1'b1; load_state = v;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic send(input logic [2:0] a, input logic [17:0] e);
    @(negedge clk);
    act_valid = 1'b1; action = a;
    exp_q.push_back(e);
    @(negedge clk);
    act_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 6 && exp_q.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d steps outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_ready(input string name);
    int i;
    i = 0;
    while (!act_ready && i < 64) begin @(negedge clk); i++; end
    n_vec++;
    if (act_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready: got act_ready=%b, expected 1 within 64 cycles", name, act_ready);
    end
  endtask

  task automatic test_reset();
    int es;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({encoded_state, step_valid, reward, done, act_ready} !== 20'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got state=%0d sv=%b rw=%0d done=%b rdy=%b, expected all 0",
               encoded_state, step_valid, reward, done, act_ready);
    end
    rst_n = 1'b1;
    wait_ready("reset");
    es = encoded_state;
    n_vec++;
    if (!(es < 500)) begin
      n_err++;
      $display("FAIL reset_range: got state=%0d, expected <500", es);
    end
    n_vec++;
    if ((es % 4) == ((es / 4) % 5)) begin
      n_err++;
      $display("FAIL reset_pass_dest: got pass=%0d dest=%0d, expected different", (es / 4) % 5, es % 4);
    end
  endtask

  task automatic test_move();
    load(9'd246);
    send(3'd1, {9'd146, 8'hFF, 1'b0});
    drain("move_n");
    load(9'd21);
    send(3'd2, {9'd21, 8'hFF, 1'b0});
    drain("wall_e");
    load(9'd446);
    send(3'd0, {9'd446, 8'hFF, 1'b0});
    drain("edge_s");
    load(9'd142);   // r1 c2: west wall
    send(3'd3, {9'd142, 8'hFF, 1'b0});
    drain("wall_w");
  endtask

  task automatic test_pickup();
    load(9'd1);
    send(3'd4, {9'd17, 8'hFF, 1'b0});
    send(3'd4, {9'd17, 8'hF6, 1'b0});
    send(3'd7, {9'd17, 8'hF6, 1'b0});
    drain("pickup");
    load(9'd417);   // r4 c0 in taxi, dest G: drop at Y
    send(3'd5, {9'd409, 8'hFF, 1'b0});
    drain("drop_other");
  endtask

  task automatic test_dropoff_done();
    load(9'd97);
    send(3'd5, {9'd85, 8'h14, 1'b1});
    drain("dropoff");
    n_vec++;
    if (act_ready !== 1'b0 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_hold: got rdy=%b done=%b, expected rdy=0 done=1", act_ready, done);
    end
    @(negedge clk);
    act_valid = 1'b1; action = 3'd0;
    repeat (4) @(negedge clk);
    act_valid = 1'b0;
    n_vec++;
    if (encoded_state !== 9'd85 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_ignore: got state=%0d done=%b, expected state=85 done=1", encoded_state, done);
    end
    load(9'd1);
    n_vec++;
    if (done !== 1'b0 || act_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_clears: got done=%b rdy=%b, expected done=0 rdy=1", done, act_ready);
    end
  endtask

  task automatic test_load_ignore();
    load(9'd246);
    load(9'd500);
    load(9'd511);
    n_vec++;
    if (encoded_state !== 9'd246 || act_ready !== 1'b1) begin
      n_err++;
      $display("FAIL load_ignore: got state=%0d rdy=%b, expected state=246 rdy=1", encoded_state, act_ready);
    end
  endtask

  task automatic test_back_to_back();
    load(9'd246);
    @(negedge clk);
    act_valid = 1'b1; action = 3'd0;
    exp_q.push_back({9'd346, 8'hFF, 1'b0});
    @(negedge clk);
    exp_q.push_back({9'd446, 8'hFF, 1'b0});
    @(negedge clk);
    exp_q.push_back({9'd446, 8'hFF, 1'b0});
    @(negedge clk);
    act_valid = 1'b0;
    drain("b2b");
  endtask

  task automatic test_random();
    int s, a;
    for (int i = 0; i < 60; i++) begin
      s = $urandom_range(0, 499);
      a = $urandom_range(0, 7);
      load(s[8:0]);
      send(a[2:0], model(s, a));
    end
    drain("random");
  endtask

  task automatic test_env_reset_and_rst();
    load(9'd246);
    @(negedge clk);
    env_reset = 1'b1; act_valid = 1'b1; action = 3'd1;
    @(negedge clk);
    n_vec++;
    if (step_valid !== 1'b0 || act_ready !== 1'b0) begin
      n_err++;
      $display("FAIL env_reset_prio: got sv=%b rdy=%b, expected sv=0 rdy=0", step_valid, act_ready);
    end
    env_reset = 1'b0; act_valid = 1'b0;
    wait_ready("reseed");
    load(9'd246);
    @(negedge clk);
    act_valid = 1'b1; action = 3'd1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    act_valid = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({encoded_state, step_valid, reward, done, act_ready} !== 20'd0) begin
      n_err++;
      $display("FAIL rst_mid_step: got state=%0d sv=%b rw=%0d done=%b rdy=%b, expected all 0",
               encoded_state, step_valid, reward, done, act_ready);
    end
    rst_n = 1'b1;
    wait_ready("post_rst");
  endtask

  initial begin
    test_reset();
    test_move();
    test_pickup();
    test_dropoff_done();
    test_load_ignore();
    test_back_to_back();
    test_random();
    test_env_reset_and_rst();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
